mc_control_unit: RTL and testbench

- Multi-cycle successor to the single-cycle MIPS control unit.
- Moore FSM (plus a few Mealy strobes) sequences fetch/decode/execute/memory/writeback over several clocks for R-type, lw, sw and beq instructions.
- Adds a memory-ready handshake with a stall timeout, illegal-opcode detection and a debug state output.
- Sits between the instruction register and the multi-cycle datapath muxes, register file and ALU control.

---
 rtl/mc_ctrl_pkg.sv | 50 +++++
 rtl/mc_wait_timer.sv | 35 +++
 rtl/mc_control_unit.sv | 178 +++++++++++++++++
 tb/tb_mc_control_unit.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared constants for the multi-cycle MIPS control unit: state encodings,
// opcodes and datapath mux select codes.
package mc_ctrl_pkg;

    localparam int unsigned OPCODE_W = 6;
    localparam int unsigned ALUOP_W  = 2;
    localparam int unsigned STATE_W  = 4;

    // FSM state encodings (also visible on state_dbg)
    localparam logic [STATE_W-1:0] S_FETCH   = 4'd0;
    localparam logic [STATE_W-1:0] S_DECODE  = 4'd1;
    localparam logic [STATE_W-1:0] S_MEMADDR = 4'd2;
    localparam logic [STATE_W-1:0] S_MEMRD   = 4'd3;
    localparam logic [STATE_W-1:0] S_MEMWB   = 4'd4;
    localparam logic [STATE_W-1:0] S_MEMWR   = 4'd5;
    localparam logic [STATE_W-1:0] S_EXEC    = 4'd6;
    localparam logic [STATE_W-1:0] S_RWB     = 4'd7;
    localparam logic [STATE_W-1:0] S_BRANCH  = 4'd8;
    localparam logic [STATE_W-1:0] S_JUMP    = 4'd9;
    localparam logic [STATE_W-1:0] S_FAULT   = 4'd15;

    // Supported opcodes (instr[31:26])
    localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;

    // ALUOp codes to ALU control
    localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
    localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 2'b01;
    localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = 2'b10;

    // ALU B-operand select
    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    // PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // States that hold a memory access open and therefore wait on mem_ready
    function automatic logic is_wait_state(input logic [STATE_W-1:0] st);
        return (st == S_FETCH) || (st == S_MEMRD) || (st == S_MEMWR);
    endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Consecutive memory-wait counter; flags expiry once MEM_TIMEOUT waits elapsed.
module mc_wait_timer #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic count_i,
    output logic expired_c_o
);

    localparam int unsigned TMO_W = $clog2(MEM_TIMEOUT + 1);

    logic [TMO_W-1:0] cnt_q;
    logic [TMO_W-1:0] cnt_d;

    assign expired_c_o = (cnt_q == TMO_W'(MEM_TIMEOUT));

    // Count while waiting; any completed access or state change clears
    always_comb begin
        cnt_d = '0;
        if (count_i && !expired_c_o) begin
            cnt_d = cnt_q + TMO_W'(1);
        end
    end

    // Counter register, synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle MIPS control unit: Moore FSM with Mealy fetch strobes,
// memory-ready timeout and illegal-opcode trapping.
// Optional J instruction support is enabled by defining MC_CTRL_JUMP_EN.
module mc_control_unit
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output logic                PCWrite,
    output logic                PCWriteCond,
    output logic                IorD,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                IRWrite,
    output logic                MemtoReg,
    output logic                RegDst,
    output logic                RegWrite,
    output logic                ALUSrcA,
    output logic [1:0]          ALUSrcB,
    output logic [ALUOP_W-1:0]  ALUOp,
    output logic [1:0]          PCSource,
    output logic                illegal_op,
    output logic                mem_fault,
    output logic [STATE_W-1:0]  state_dbg
);

    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_d;
    logic               illegal_op_q;
    logic               mem_fault_q;
    logic               set_illegal;
    logic               set_fault;
    logic               tmo_count;
    logic               tmo_expired;

    assign tmo_count  = is_wait_state(state_q) && !mem_ready;
    assign illegal_op = illegal_op_q;
    assign mem_fault  = mem_fault_q;
    assign state_dbg  = state_q;

    mc_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_wait_timer (
        .clk_i       (Clock),
        .rst_ni      (Reset),
        .count_i     (tmo_count),
        .expired_c_o (tmo_expired)
    );

    // Next-state and control decode from current state (fetch strobes also use mem_ready)
    always_comb begin
        state_d     = state_q;
        set_illegal = 1'b0;
        set_fault   = 1'b0;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SRCB_B;
        ALUOp       = ALUOP_ADD;
        PCSource    = PCSRC_ALU;

        case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = SRCB_FOUR;
                if (mem_ready) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    state_d = S_DECODE;
                end else if (tmo_expired) begin
                    set_fault = 1'b1;
                    state_d   = S_FAULT;
                end
            end
            S_DECODE: begin
                ALUSrcB = SRCB_IMM_SH;
                case (opcode)
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_LW, OP_SW: state_d = S_MEMADDR;
                    OP_BEQ:       state_d = S_BRANCH;
`ifdef MC_CTRL_JUMP_EN
                    OP_J:         state_d = S_JUMP;
`endif
                    default: begin
                        set_illegal = 1'b1;
                        state_d     = S_FAULT;
                    end
                endcase
            end
            S_MEMADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (mem_ready) begin
                    state_d = S_MEMWB;
                end else if (tmo_expired) begin
                    set_fault = 1'b1;
                    state_d   = S_FAULT;
                end
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
                state_d  = S_FETCH;
            end
            S_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                if (mem_ready) begin
                    state_d = S_FETCH;
                end else if (tmo_expired) begin
                    set_fault = 1'b1;
                    state_d   = S_FAULT;
                end
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALUOP_FUNCT;
                state_d = S_RWB;
            end
            S_RWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = ALUOP_SUB;
                PCWriteCond = 1'b1;
                PCSource    = PCSRC_ALUOUT;
                state_d     = S_FETCH;
            end
`ifdef MC_CTRL_JUMP_EN
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = PCSRC_JUMP;
                state_d  = S_FETCH;
            end
`endif
            S_FAULT: begin
                state_d = S_FAULT;
            end
            default: begin
                // Unused encodings are treated as a corrupted state
                state_d = S_FAULT;
            end
        endcase
    end

    // State and sticky fault flags; reset overrides everything including FAULT
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q      <= S_FETCH;
            illegal_op_q <= 1'b0;
            mem_fault_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            illegal_op_q <= illegal_op_q | set_illegal;
            mem_fault_q  <= mem_fault_q | set_fault;
        end
    end

endmodule

// File: tb/tb_mc_control_unit.sv
// Self-checking bench for mc_control_unit: builds expected per-cycle traces
// of each instruction class and compares state and control vectors.
module tb_mc_control_unit;

    localparam int unsigned MEMTMO = 4;

    localparam logic [3:0] S_FETCH   = 4'd0;
    localparam logic [3:0] S_DECODE  = 4'd1;
    localparam logic [3:0] S_MEMADDR = 4'd2;
    localparam logic [3:0] S_MEMRD   = 4'd3;
    localparam logic [3:0] S_MEMWB   = 4'd4;
    localparam logic [3:0] S_MEMWR   = 4'd5;
    localparam logic [3:0] S_EXEC    = 4'd6;
    localparam logic [3:0] S_RWB     = 4'd7;
    localparam logic [3:0] S_BRANCH  = 4'd8;
    localparam logic [3:0] S_JUMP    = 4'd9;
    localparam logic [3:0] S_FAULT   = 4'd15;

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] OP_BAD = 6'b111111;

    localparam int K_R = 0, K_LW = 1, K_SW = 2, K_BEQ = 3, K_J = 4;

    logic       Clock, Reset, mem_ready;
    logic [5:0] opcode;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic       illegal_op, mem_fault;
    logic [3:0] state_dbg;
    logic [15:0] act_vec;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        logic [3:0] st;
        logic       rdy;
        logic [5:0] op;
        logic       ill;
        logic       mf;
    } ent_t;

    ent_t tq[$];

    mc_control_unit #(.MEM_TIMEOUT(MEMTMO)) dut (
        .Clock(Clock), .Reset(Reset), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSource(PCSource), .illegal_op(illegal_op), .mem_fault(mem_fault),
        .state_dbg(state_dbg)
    );

    assign act_vec = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                      MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource};

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    // Control vector each state must present, straight from the state table
    function automatic logic [15:0] exp_vec(input logic [3:0] st, input logic rdy);
        logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca;
        logic [1:0] srcb, aop, pcs;
        {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca} = '0;
        srcb = 2'b00; aop = 2'b00; pcs = 2'b00;
        case (st)
            S_FETCH:   begin mrd = 1'b1; srcb = 2'b01; irw = rdy; pcw = rdy; end
            S_DECODE:  srcb = 2'b11;
            S_MEMADDR: begin srca = 1'b1; srcb = 2'b10; end
            S_MEMRD:   begin mrd = 1'b1; iord = 1'b1; end
            S_MEMWB:   begin rw = 1'b1; m2r = 1'b1; end
            S_MEMWR:   begin mwr = 1'b1; iord = 1'b1; end
            S_EXEC:    begin srca = 1'b1; aop = 2'b10; end
            S_RWB:     begin rw = 1'b1; rdst = 1'b1; end
            S_BRANCH:  begin srca = 1'b1; aop = 2'b01; pcwc = 1'b1; pcs = 2'b01; end
            S_JUMP:    begin pcw = 1'b1; pcs = 2'b10; end
            default:   ;
        endcase
        return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca, srcb, aop, pcs};
    endfunction

    function automatic void push(input logic [3:0] st, input logic rdy,
                                 input logic [5:0] op, input logic ill, input logic mf);
        ent_t e;
        e.st = st; e.rdy = rdy; e.op = op; e.ill = ill; e.mf = mf;
        tq.push_back(e);
    endfunction

    // w cycles of waiting then completion; opcode bus is don't-care during fetch
    function automatic void push_wait(input logic [3:0] st, input int w, input logic [5:0] op);
        for (int k = 0; k < w; k++)
            push(st, 1'b0, (st == S_FETCH) ? 6'($urandom()) : op, 1'b0, 1'b0);
        push(st, 1'b1, (st == S_FETCH) ? 6'($urandom()) : op, 1'b0, 1'b0);
    endfunction

    // Expected cycle-by-cycle trace of one legal instruction
    function automatic void push_instr(input int kind, input int wf, input int wm);
        logic [5:0] op;
        case (kind)
            K_R:     op = OP_R;
            K_LW:    op = OP_LW;
            K_SW:    op = OP_SW;
            K_BEQ:   op = OP_BEQ;
            default: op = OP_J;
        endcase
        push_wait(S_FETCH, wf, op);
        push(S_DECODE, 1'($urandom()), op, 1'b0, 1'b0);
        case (kind)
            K_R: begin
                push(S_EXEC, 1'($urandom()), op, 1'b0, 1'b0);
                push(S_RWB, 1'($urandom()), op, 1'b0, 1'b0);
            end
            K_LW: begin
                push(S_MEMADDR, 1'($urandom()), op, 1'b0, 1'b0);
                push_wait(S_MEMRD, wm, op);
                push(S_MEMWB, 1'($urandom()), op, 1'b0, 1'b0);
            end
            K_SW: begin
                push(S_MEMADDR, 1'($urandom()), op, 1'b0, 1'b0);
                push_wait(S_MEMWR, wm, op);
            end
            K_BEQ:   push(S_BRANCH, 1'($urandom()), op, 1'b0, 1'b0);
            default: push(S_JUMP, 1'($urandom()), op, 1'b0, 1'b0);
        endcase
    endfunction

    // Stuck in FAULT: inputs are random and must be ignored
    function automatic void push_fault(input int n, input logic ill, input logic mf);
        for (int k = 0; k < n; k++)
            push(S_FAULT, 1'($urandom()), 6'($urandom()), ill, mf);
    endfunction

    task automatic drive_step(input ent_t e);
        opcode    = e.op;
        mem_ready = e.rdy;
        #1;
    endtask

    // Reset for two edges, release; leaves the bench mid-cycle in FETCH
    task automatic apply_reset();
        Reset     = 1'b0;
        mem_ready = 1'($urandom());
        opcode    = 6'($urandom());
        repeat (2) @(negedge Clock);
        Reset     = 1'b1;
        mem_ready = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        apply_reset();
        n_assert++;
        if (state_dbg !== S_FETCH) begin
            n_fail++;
            $display("FAIL reset_state: got %0d want %0d", state_dbg, S_FETCH);
        end
        n_assert++;
        if ({act_vec, illegal_op, mem_fault} !== {16'h1010, 2'b00}) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %h want %h", {act_vec, illegal_op, mem_fault}, {16'h1010, 2'b00});
        end
    endtask

    task automatic test_rtype();
        ent_t e;
        tq.delete();
        push_instr(K_R, 0, 0);
        push_instr(K_R, 0, 0);
        for (int i = 0; tq.size() > 0; i++) begin
            e = tq.pop_front();
            drive_step(e);
            n_assert++;
            if (state_dbg !== e.st) begin
                n_fail++;
                $display("FAIL rtype_state[%0d]: got %0d want %0d", i, state_dbg, e.st);
            end
            n_assert++;
            if ({act_vec, illegal_op, mem_fault} !== {exp_vec(e.st, e.rdy), e.ill, e.mf}) begin
                n_fail++;
                $display("FAIL rtype_ctrl[%0d]: got %h want %h", i,
                         {act_vec, illegal_op, mem_fault}, {exp_vec(e.st, e.rdy), e.ill, e.mf});
            end
            @(negedge Clock);
        end
    endtask

    task automatic test_lw_wait();
        ent_t e;
        tq.delete();
        push_instr(K_LW, 0, 3);
        for (int i = 0; tq.size() > 0; i++) begin
            e = tq.pop_front();
            drive_step(e);
            n_assert++;
            if (state_dbg !== e.st) begin
                n_fail++;
                $display("FAIL lw_state[%0d]: got %0d want %0d", i, state_dbg, e.st);
            end
            n_assert++;
            if ({act_vec, illegal_op, mem_fault} !== {exp_vec(e.st, e.rdy), e.ill, e.mf}) begin
                n_fail++;
                $display("FAIL lw_ctrl[%0d]: got %h want %h", i,
                         {act_vec, illegal_op, mem_fault}, {exp_vec(e.st, e.rdy), e.ill, e.mf});
            end
            @(negedge Clock);
        end
    endtask

    task automatic test_sw_beq();
        ent_t e;
        tq.delete();
        push_instr(K_SW, 1, 2);
        push_instr(K_BEQ, 0, 0);
        push_instr(K_SW, 0, 0);
        for (int i = 0; tq.size() > 0; i++) begin
            e = tq.pop_front();
            drive_step(e);
            n_assert++;
            if (state_dbg !== e.st) begin
                n_fail++;
                $display("FAIL swbeq_state[%0d]: got %0d want %0d", i, state_dbg, e.st);
            end
            n_assert++;
            if ({act_vec, illegal_op, mem_fault} !== {exp_vec(e.st, e.rdy), e.ill, e.mf}) begin
                n_fail++;
                $display("FAIL swbeq_ctrl[%0d]: got %h want %h", i,
                         {act_vec, illegal_op, mem_fault}, {exp_vec(e.st, e.rdy), e.ill, e.mf});
            end
            @(negedge Clock);
        end
    endtask

    // Illegal opcode and J; J is legal only when the jump option is built in
    task automatic test_illegal_jump();
        ent_t e;
        for (int pass = 0; pass < 2; pass++) begin
            tq.delete();
            if (pass == 0) begin
                push_wait(S_FETCH, 1, OP_BAD);
                push(S_DECODE, 1'($urandom()), OP_BAD, 1'b0, 1'b0);
                push_fault(4, 1'b1, 1'b0);
            end else begin
`ifdef MC_CTRL_JUMP_EN
                push_instr(K_J, 0, 0);
                push_instr(K_R, 0, 0);
`else
                push_wait(S_FETCH, 0, OP_J);
                push(S_DECODE, 1'($urandom()), OP_J, 1'b0, 1'b0);
                push_fault(3, 1'b1, 1'b0);
`endif
            end
            for (int i = 0; tq.size() > 0; i++) begin
                e = tq.pop_front();
                drive_step(e);
                n_assert++;
                if (state_dbg !== e.st) begin
                    n_fail++;
                    $display("FAIL illegal_state[p%0d,%0d]: got %0d want %0d", pass, i, state_dbg, e.st);
                end
                n_assert++;
                if ({act_vec, illegal_op, mem_fault} !== {exp_vec(e.st, e.rdy), e.ill, e.mf}) begin
                    n_fail++;
                    $display("FAIL illegal_ctrl[p%0d,%0d]: got %h want %h", pass, i,
                             {act_vec, illegal_op, mem_fault}, {exp_vec(e.st, e.rdy), e.ill, e.mf});
                end
                @(negedge Clock);
            end
            if (state_dbg == S_FAULT || pass == 0) begin
                apply_reset();
                n_assert++;
                if ({state_dbg, illegal_op, mem_fault} !== {S_FETCH, 2'b00}) begin
                    n_fail++;
                    $display("FAIL illegal_reset[p%0d]: got %h want %h", pass,
                             {state_dbg, illegal_op, mem_fault}, {S_FETCH, 2'b00});
                end
            end
        end
    endtask

    // Timeout in each wait state, plus completion exactly at the limit
    task automatic test_timeout();
        ent_t e;
        for (int where = 0; where < 3; where++) begin
            tq.delete();
            push_instr(K_R, MEMTMO, 0);
            if (where == 0) begin
                for (int k = 0; k <= int'(MEMTMO); k++)
                    push(S_FETCH, 1'b0, 6'($urandom()), 1'b0, 1'b0);
            end else begin
                push_instr((where == 1) ? K_LW : K_SW, 0, MEMTMO);
                push_wait(S_FETCH, 0, (where == 1) ? OP_LW : OP_SW);
                push(S_DECODE, 1'b0, (where == 1) ? OP_LW : OP_SW, 1'b0, 1'b0);
                push(S_MEMADDR, 1'b0, (where == 1) ? OP_LW : OP_SW, 1'b0, 1'b0);
                for (int k = 0; k <= int'(MEMTMO); k++)
                    push((where == 1) ? S_MEMRD : S_MEMWR, 1'b0, (where == 1) ? OP_LW : OP_SW, 1'b0, 1'b0);
            end
            push_fault(3, 1'b0, 1'b1);
            for (int i = 0; tq.size() > 0; i++) begin
                e = tq.pop_front();
                drive_step(e);
                n_assert++;
                if (state_dbg !== e.st) begin
                    n_fail++;
                    $display("FAIL tmo_state[w%0d,%0d]: got %0d want %0d", where, i, state_dbg, e.st);
                end
                n_assert++;
                if ({act_vec, illegal_op, mem_fault} !== {exp_vec(e.st, e.rdy), e.ill, e.mf}) begin
                    n_fail++;
                    $display("FAIL tmo_ctrl[w%0d,%0d]: got %h want %h", where, i,
                             {act_vec, illegal_op, mem_fault}, {exp_vec(e.st, e.rdy), e.ill, e.mf});
                end
                @(negedge Clock);
            end
            apply_reset();
            n_assert++;
            if ({state_dbg, illegal_op, mem_fault} !== {S_FETCH, 2'b00}) begin
                n_fail++;
                $display("FAIL tmo_reset[w%0d]: got %h want %h", where,
                         {state_dbg, illegal_op, mem_fault}, {S_FETCH, 2'b00});
            end
        end
    endtask

    // Random legal instruction stream with random waits up to the limit
    task automatic test_back_to_back();
        ent_t e;
        int   kmax;
`ifdef MC_CTRL_JUMP_EN
        kmax = K_J;
`else
        kmax = K_BEQ;
`endif
        tq.delete();
        for (int n = 0; n < 40; n++)
            push_instr($urandom_range(kmax, 0), $urandom_range(MEMTMO, 0), $urandom_range(MEMTMO, 0));
        for (int i = 0; tq.size() > 0; i++) begin
            e = tq.pop_front();
            drive_step(e);
            n_assert++;
            if (state_dbg !== e.st) begin
                n_fail++;
                $display("FAIL b2b_state[%0d]: got %0d want %0d", i, state_dbg, e.st);
            end
            n_assert++;
            if ({act_vec, illegal_op, mem_fault} !== {exp_vec(e.st, e.rdy), e.ill, e.mf}) begin
                n_fail++;
                $display("FAIL b2b_ctrl[%0d]: got %h want %h", i,
                         {act_vec, illegal_op, mem_fault}, {exp_vec(e.st, e.rdy), e.ill, e.mf});
            end
            @(negedge Clock);
        end
    endtask

    initial begin
        Reset     = 1'b0;
        mem_ready = 1'b0;
        opcode    = '0;
        @(negedge Clock);
        test_reset();
        test_rtype();
        test_lw_wait();
        test_sw_beq();
        test_illegal_jump();
        test_timeout();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
